riscv_checkpoint_monitor: RTL and testbench

RISCV_CHECKPOINT_MONITOR -- requirements
Module: riscv_checkpoint_monitor

---
 rtl/riscv_checkpoint_monitor.sv | 136 +++++++++++++
 tb/tb_riscv_checkpoint_monitor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_checkpoint_monitor.sv
// Checkpoint monitor: compares a core's output port against a table of
// (instruction count, expected value) pairs while the core runs, then reports.
module riscv_checkpoint_monitor #(
    parameter int NUM_TEST     = 40,
    parameter int IW           = 32,
    parameter int DW           = 32,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                            CLK,
    input  logic                            RSTn,
    input  logic                            LD_EN,
    input  logic [$clog2(NUM_TEST)-1:0]     LD_IDX,
    input  logic [IW-1:0]                   LD_INST,
    input  logic [DW-1:0]                   LD_ANS,
    input  logic [$clog2(NUM_TEST+1)-1:0]   N_ACTIVE,
    input  logic                            START,
    input  logic [IW-1:0]                   NUM_INST,
    input  logic [DW-1:0]                   OUTPUT_PORT,
    input  logic                            HALT,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            SUCCESS,
    output logic [$clog2(NUM_TEST+1)-1:0]   PTR,
    output logic [$clog2(NUM_TEST+1)-1:0]   PASS_CNT,
    output logic [$clog2(NUM_TEST+1)-1:0]   FAIL_CNT,
    output logic [$clog2(NUM_TEST)-1:0]     FAIL_IDX,
    output logic [DW-1:0]                   FAIL_GOT,
    output logic                            FAIL_MISS,
    output logic [31:0]                     CYCLE
);
    localparam int XW = $clog2(NUM_TEST);
    localparam int CW = $clog2(NUM_TEST+1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t          state_reg;
    logic [CW-1:0]   n_active_reg;
    logic [IW-1:0]   inst_mem [NUM_TEST];
    logic [DW-1:0]   ans_mem  [NUM_TEST];

    always_ff @(posedge CLK) begin
        if (LD_EN && state_reg == S_IDLE) begin
            inst_mem[LD_IDX] <= LD_INST;
            ans_mem[LD_IDX]  <= LD_ANS;
        end
    end

    // The pending entry must be compared in the same cycle it is addressed,
    // so the table is read combinationally at PTR.
    logic [XW-1:0] cur_idx;
    logic [IW-1:0] cur_inst;
    logic [DW-1:0] cur_ans;
    logic          active, hit, late, eval, good, bad;
    logic [CW-1:0] ptr_after, fail_cnt_after;
    logic          halt_pass, halt_miss;

    always_comb begin
        cur_idx        = PTR[XW-1:0];
        cur_inst       = inst_mem[cur_idx];
        cur_ans        = ans_mem[cur_idx];
        active         = PTR < n_active_reg;
        hit            = active && (NUM_INST == cur_inst);
        late           = active && (NUM_INST > cur_inst);
        eval           = hit || late;
        good           = hit && (OUTPUT_PORT == cur_ans);
        bad            = eval && !good;
        ptr_after      = PTR + CW'(eval);
        fail_cnt_after = FAIL_CNT + CW'(bad);
        halt_pass      = (fail_cnt_after == '0) && (ptr_after == n_active_reg);
        halt_miss      = HALT && (fail_cnt_after == '0) && !halt_pass;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg    <= S_IDLE;
            n_active_reg <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            SUCCESS      <= 1'b0;
            PTR          <= '0;
            PASS_CNT     <= '0;
            FAIL_CNT     <= '0;
            FAIL_IDX     <= '0;
            FAIL_GOT     <= '0;
            FAIL_MISS    <= 1'b0;
            CYCLE        <= '0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (CYCLE != '1)
                        CYCLE <= CYCLE + 32'd1;
                    PTR      <= ptr_after;
                    PASS_CNT <= PASS_CNT + CW'(good);
                    FAIL_CNT <= fail_cnt_after;
                    if (bad && FAIL_CNT == '0) begin
                        FAIL_IDX  <= cur_idx;
                        FAIL_GOT  <= OUTPUT_PORT;
                        FAIL_MISS <= late && !hit;
                    end else if (halt_miss) begin
                        // Halted early: blame the first checkpoint never reached.
                        FAIL_IDX  <= ptr_after[XW-1:0];
                        FAIL_GOT  <= OUTPUT_PORT;
                        FAIL_MISS <= 1'b1;
                    end
                    if ((STOP_ON_FAIL != 0 && bad) || (HALT && !halt_pass)) begin
                        state_reg <= S_FAIL;
                        BUSY      <= 1'b0;
                        DONE      <= 1'b1;
                        SUCCESS   <= 1'b0;
                    end else if (HALT) begin
                        state_reg <= S_PASS;
                        BUSY      <= 1'b0;
                        DONE      <= 1'b1;
                        SUCCESS   <= 1'b1;
                    end
                end
                default: begin
                    if (START) begin
                        state_reg    <= S_RUN;
                        n_active_reg <= N_ACTIVE;
                        BUSY         <= 1'b1;
                        DONE         <= 1'b0;
                        SUCCESS      <= 1'b0;
                        PTR          <= '0;
                        PASS_CNT     <= '0;
                        FAIL_CNT     <= '0;
                        FAIL_IDX     <= '0;
                        FAIL_GOT     <= '0;
                        FAIL_MISS    <= 1'b0;
                        CYCLE        <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// Runs two monitors (continue-on-fail and stop-on-fail) on identical stimulus
// and scoreboards each final report against a checkpoint-list model.
module tb_riscv_checkpoint_monitor;
    localparam int NT = 40;

    typedef struct {
        logic [31:0] num;
        logic [31:0] out;
        bit          halt;
    } vec_t;

    typedef struct {
        int          success;
        int          pass_cnt;
        int          fail_cnt;
        int          fail_idx;
        logic [31:0] fail_got;
        int          fail_miss;
        int          ptr;
        int          cycles;
    } res_t;

    logic        CLK = 1'b0;
    logic        RSTn, LD_EN, START, HALT;
    logic [5:0]  LD_IDX, N_ACTIVE;
    logic [31:0] LD_INST, LD_ANS, NUM_INST, OUTPUT_PORT;

    logic [1:0]  busy, done, success, fail_miss;
    logic [5:0]  ptr [2];
    logic [5:0]  pass_cnt [2];
    logic [5:0]  fail_cnt [2];
    logic [5:0]  fail_idx [2];
    logic [31:0] fail_got [2];
    logic [31:0] cycle [2];

    always #5 CLK = ~CLK;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            riscv_checkpoint_monitor #(
                .NUM_TEST(NT), .IW(32), .DW(32), .STOP_ON_FAIL(gi)
            ) dut (
                .CLK(CLK), .RSTn(RSTn), .LD_EN(LD_EN), .LD_IDX(LD_IDX),
                .LD_INST(LD_INST), .LD_ANS(LD_ANS), .N_ACTIVE(N_ACTIVE),
                .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT),
                .HALT(HALT), .BUSY(busy[gi]), .DONE(done[gi]),
                .SUCCESS(success[gi]), .PTR(ptr[gi]), .PASS_CNT(pass_cnt[gi]),
                .FAIL_CNT(fail_cnt[gi]), .FAIL_IDX(fail_idx[gi]),
                .FAIL_GOT(fail_got[gi]), .FAIL_MISS(fail_miss[gi]),
                .CYCLE(cycle[gi])
            );
        end
    endgenerate

    int          n_cmp = 0;
    int          n_bad = 0;
    int          run_no = 0;
    logic [31:0] t_inst [NT];
    logic [31:0] t_ans  [NT];
    vec_t        vec_q [$];
    res_t        exp_q0 [$];
    res_t        exp_q1 [$];
    logic [1:0]  done_prev = 2'b00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Expected final report: walk the checkpoint list against the per-cycle
    // observations, one entry at most per cycle.
    function automatic res_t model(input int n, input bit stop);
        res_t r;
        int   p;
        bit   bad;
        r.success = 0; r.pass_cnt = 0; r.fail_cnt = 0; r.fail_idx = 0;
        r.fail_got = '0; r.fail_miss = 0; r.ptr = 0; r.cycles = 0;
        p = 0;
        for (int c = 0; c < vec_q.size(); c++) begin
            bad = 0;
            r.cycles = c + 1;
            if (p < n && vec_q[c].num >= t_inst[p]) begin
                if (vec_q[c].num == t_inst[p] && vec_q[c].out == t_ans[p])
                    r.pass_cnt++;
                else begin
                    if (r.fail_cnt == 0) begin
                        r.fail_idx  = p;
                        r.fail_got  = vec_q[c].out;
                        r.fail_miss = (vec_q[c].num != t_inst[p]) ? 1 : 0;
                    end
                    r.fail_cnt++;
                    bad = 1;
                end
                p++;
            end
            if (stop && bad) break;
            if (vec_q[c].halt) begin
                if (r.fail_cnt == 0 && p == n) r.success = 1;
                else if (r.fail_cnt == 0) begin
                    r.fail_idx  = p;
                    r.fail_got  = vec_q[c].out;
                    r.fail_miss = 1;
                end
                break;
            end
        end
        r.ptr = p;
        return r;
    endfunction

    task automatic check_res(input int k, input res_t e);
        string s;
        s = $sformatf("run%0d_dut%0d", run_no, k);
        $display("run %0d dut%0d: success=%0d pass_cnt=%0d fail_cnt=%0d ptr=%0d cycle=%0d",
                 run_no, k, success[k], pass_cnt[k], fail_cnt[k], ptr[k], cycle[k]);
        chk({s, "_success"},   32'(success[k]),   32'(e.success));
        chk({s, "_pass_cnt"},  32'(pass_cnt[k]),  32'(e.pass_cnt));
        chk({s, "_fail_cnt"},  32'(fail_cnt[k]),  32'(e.fail_cnt));
        chk({s, "_ptr"},       32'(ptr[k]),       32'(e.ptr));
        chk({s, "_fail_idx"},  32'(fail_idx[k]),  32'(e.fail_idx));
        chk({s, "_fail_got"},  fail_got[k],       e.fail_got);
        chk({s, "_fail_miss"}, 32'(fail_miss[k]), 32'(e.fail_miss));
        chk({s, "_cycle"},     cycle[k],          32'(e.cycles));
    endtask

    // Monitor: every rising DONE retires one expected report.
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (done[k] && !done_prev[k]) begin
                if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done dut%0d: got DONE rise, required none", k);
                end else if (k == 0)
                    check_res(0, exp_q0.pop_front());
                else
                    check_res(1, exp_q1.pop_front());
            end
        end
        done_prev = done;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RSTn = 1'b0; START = 1'b0; LD_EN = 1'b0; HALT = 1'b0;
        tick;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_flags_dut%0d", k),
                32'({busy[k], done[k], success[k], ptr[k], pass_cnt[k],
                     fail_cnt[k], fail_idx[k], fail_miss[k]}), 32'd0);
            chk($sformatf("reset_cycle_dut%0d", k), cycle[k], 32'd0);
            chk($sformatf("reset_fail_got_dut%0d", k), fail_got[k], 32'd0);
        end
        RSTn = 1'b1;
    endtask

    task automatic load_table(input int n);
        for (int i = 0; i < n; i++) begin
            LD_EN = 1'b1; LD_IDX = 6'(i); LD_INST = t_inst[i]; LD_ANS = t_ans[i];
            tick;
        end
        LD_EN = 1'b0;
    endtask

    task automatic add_vec(input logic [31:0] num, input logic [31:0] out, input bit halt);
        vec_t v;
        v.num = num; v.out = out; v.halt = halt;
        vec_q.push_back(v);
    endtask

    task automatic run_vectors(input int n, input bit noise);
        run_no++;
        exp_q0.push_back(model(n, 1'b0));
        exp_q1.push_back(model(n, 1'b1));
        START = 1'b1; N_ACTIVE = 6'(n);
        tick;
        START = 1'b0;
        foreach (vec_q[c]) begin
            NUM_INST = vec_q[c].num; OUTPUT_PORT = vec_q[c].out; HALT = vec_q[c].halt;
            if (noise) begin
                LD_EN = 1'b1; LD_IDX = 6'($urandom_range(0, 7));
                LD_INST = $urandom; LD_ANS = $urandom;
            end
            tick;
        end
        HALT = 1'b0; LD_EN = 1'b0;
        tick;
        tick;
        chk($sformatf("run%0d_drained_dut0", run_no), 32'(exp_q0.size()), 32'd0);
        chk($sformatf("run%0d_drained_dut1", run_no), 32'(exp_q1.size()), 32'd0);
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic abort_run;
        START = 1'b1; N_ACTIVE = 6'd3;
        tick;
        START = 1'b0; NUM_INST = 32'd1; OUTPUT_PORT = 32'd0;
        tick;
        tick;
        do_reset;
    endtask

    task automatic random_vectors(input int n);
        logic [31:0] cur, last, o;
        int          r;
        bit          h;
        vec_q.delete();
        cur  = 32'd0;
        last = (n > 0) ? t_inst[n-1] : 32'd2;
        forever begin
            r = $urandom_range(0, 99);
            if (r >= 25 && r < 85) cur = cur + 32'd1;
            else if (r >= 85)      cur = cur + 32'($urandom_range(2, 4));
            o = $urandom;
            for (int j = 0; j < n; j++)
                if (t_inst[j] == cur && $urandom_range(0, 99) < 85) o = t_ans[j];
            h = (cur > last + 32'd1) || (vec_q.size() >= 60) || ($urandom_range(0, 99) < 3);
            add_vec(cur, o, h);
            if (h) break;
        end
    endtask

    initial begin
        RSTn = 1'b0; LD_EN = 1'b0; START = 1'b0; HALT = 1'b0;
        LD_IDX = '0; LD_INST = '0; LD_ANS = '0; N_ACTIVE = '0;
        NUM_INST = '0; OUTPUT_PORT = '0;
        tick;
        do_reset;

        t_inst[0] = 32'd4; t_ans[0] = 32'h0F00;
        t_inst[1] = 32'd6; t_ans[1] = 32'h18;
        t_inst[2] = 32'd8; t_ans[2] = 32'h1D;
        load_table(3);

        // All match, with table-write noise while running.
        vec_q.delete();
        add_vec(4, 32'h0F00, 0); add_vec(6, 32'h18, 0); add_vec(8, 32'h1D, 0); add_vec(8, 32'h1D, 1);
        run_vectors(3, 1'b1);
        // Mismatch on entry 1 (rerun from PASS with retained table).
        vec_q.delete();
        add_vec(4, 32'h0F00, 0); add_vec(6, 32'h19, 0); add_vec(8, 32'h1D, 0); add_vec(8, 32'h1D, 1);
        run_vectors(3, 1'b0);
        // Skipped checkpoint 6.
        vec_q.delete();
        add_vec(4, 32'h0F00, 0); add_vec(7, 32'h55, 0); add_vec(8, 32'h1D, 0); add_vec(8, 32'h1D, 1);
        run_vectors(3, 1'b0);
        // Held count: checked once.
        vec_q.delete();
        for (int i = 0; i < 5; i++) add_vec(4, 32'h0F00, 0);
        add_vec(4, 32'h0F00, 1);
        run_vectors(3, 1'b0);
        // Early halt after entry 1, then halt with final match.
        vec_q.delete();
        add_vec(4, 32'h0F00, 0); add_vec(6, 32'h18, 1);
        run_vectors(3, 1'b0);
        vec_q.delete();
        add_vec(4, 32'h0F00, 0); add_vec(6, 32'h18, 0); add_vec(8, 32'h1D, 1);
        run_vectors(3, 1'b0);
        // Empty table passes on first halt.
        vec_q.delete();
        add_vec(5, 32'h0, 1);
        run_vectors(0, 1'b0);

        abort_run;

        for (int t = 0; t < 6; t++) begin
            int n;
            logic [31:0] base;
            do_reset;
            n = $urandom_range(0, 8);
            base = 32'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) begin
                t_inst[i] = base;
                t_ans[i]  = $urandom;
                base = base + 32'($urandom_range(1, 3));
            end
            load_table(n);
            for (int r = 0; r < 5; r++) begin
                random_vectors(n);
                run_vectors(n, r[0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "timeout");
    end
endmodule
